div: RTL and testbench
======================

# div

Multicycle signed 32-bit integer divider for the MIPS-style multicycle datapath. It is the inverse-operation companion of the multiplier, driven by the same control-unit handshake. It delivers the quotient on `lo` and the remainder on `hi`, the same register pair the multiplier writes, so the `mfhi`/`mflo` paths serve both units. It uses a shift-subtract (restoring) algorithm on operand magnitudes with sign fix-up, one quotient bit per clock.

## Interface
- No parameters; width fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `x`  in  32  dividend, two's complement.
- `y`  in  32  divisor, two's complement.
- `div_control`  in  1  start request, sampled on rising edge.
- `hi`  out  32  remainder, registered.
- `lo`  out  32  quotient, registered.
- `operando`  out  1  busy; 1 from start acceptance until result written.
- `done`  out  1  one-cycle pulse on the cycle after the result is written.
- `div_zero`  out  1  set when the last completed operation had `y == 0`.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: on an edge with `div_control == 1`:
  - Capture `|x|` into the remainder/quotient shift pair and `|y|` into the divisor register.
  - Record `neg_q = x[31] ^ y[31]` and `neg_r = x[31]`.
  - Load the 6-bit iteration counter with 32. Set `operando = 1`. Clear `div_zero`.
  - If `y == 0`, go to FINISH with the zero flag recorded. Otherwise go to RUN.
- RUN, each edge:
  - Shift {R, Q} left by 1.
  - Compute trial = R − D in 33 bits.
  - If the trial is non-negative, set R = trial and Q[0] = 1. Otherwise leave R unchanged and set Q[0] = 0.
  - Decrement the counter. When it reaches 0, go to FINISH.
- FINISH, one edge:
  - Normal case: `lo = neg_q ? −Q : Q` and `hi = neg_r ? −R : R`.
  - Divide by zero: `lo = 32'hFFFFFFFF`, `hi = x` as captured, `div_zero = 1`.
  - Set `operando = 0` and go to IDLE. `done` asserts on the following cycle for exactly one cycle.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend (x = q·y + r, |r| < |y|).
  - Magnitudes are 32-bit unsigned, so |−2^31| = 0x80000000 is represented exactly.
  - Overflow case 0x80000000 / −1 yields `lo = 0x80000000`, `hi = 0`, `div_zero = 0`.
- `div_control` while `operando == 1` is ignored; no queueing.
- `x` and `y` are sampled only at acceptance and may change afterwards.
- `hi` and `lo` hold their previous values throughout an operation and change only in FINISH.

## Timing
- Reset (asynchronous, `reset == 0`): `hi = 0`, `lo = 0`, `operando = 0`, `done = 0`, `div_zero = 0`, state IDLE, counter 0.
- Reset mid-operation aborts the operation. Outputs return to reset values and no `done` pulse is produced.
- A start on the first edge after reset release is accepted.
- Acceptance edge E0 → `operando = 1` after E0.
- Edges E1..E32 perform the 32 iterations. Edge E33 writes `hi`/`lo` and drops `operando`. `done = 1` after E33, until E34.
- Divide by zero: E0 accepts, E1 writes the results. `done` is high for the cycle after E1.
- Back-to-back operation: a start asserted in the cycle after E33 (IDLE) is accepted at that edge.
  - `done` and the new `operando` may be high together.
  - `div_zero` clears at the new E0.

## Test plan
- x=100, y=7, start → `operando` high for 33 cycles; at E33 `lo = 14`, `hi = 2`, one `done` pulse, `div_zero = 0`.
- x=−100, y=7 → `lo = 0xFFFFFFF2`, `hi = 0xFFFFFFFE`. x=100, y=−7 → `lo = 0xFFFFFFF2`, `hi = 2`. x=−100, y=−7 → `lo = 14`, `hi = 0xFFFFFFFE`.
- x=7, y=0 → at E1 `lo = 0xFFFFFFFF`, `hi = 7`, `div_zero = 1`, `done` pulse at E1+1; next start clears `div_zero`.
- x=0x80000000, y=0xFFFFFFFF → `lo = 0x80000000`, `hi = 0`. x=0x80000000, y=2 → `lo = 0xC0000000`, `hi = 0`.
- Start x=100, y=7; hold `div_control = 1` and change x/y during RUN → single result 14/2 at E33; new operation accepted only at the first edge with state IDLE.
- Start, then drive `reset = 0` asynchronously between edges during RUN (e.g. after E10) → all outputs 0 immediately, no `done`. After release, start x=9, y=3 → `lo = 3`, `hi = 0` at E33.

Source files
------------

// File: rtl/div.sv
// ============================================================================
// Module   : div
// Purpose  : Multicycle signed 32-bit restoring divider. Quotient -> lo,
//            remainder -> hi, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        div_control,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        operando,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [5:0]  cnt_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        zero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        divz_q;

  logic [31:0] abs_x;
  logic [31:0] abs_y;
  logic [31:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  assign abs_x  = x[31] ? (~x + 32'd1) : x;
  assign abs_y  = y[31] ? (~y + 32'd1) : y;

  // Shifted partial remainder; it never exceeds 32 bits because R < D <= 2^31.
  assign rem_sh = {rem_q[30:0], quo_q[31]};
  assign trial  = {1'b0, rem_sh} - {1'b0, dvs_q};
  assign rem_d  = trial[32] ? rem_sh : trial[31:0];
  assign quo_d  = {quo_q[30:0], ~trial[32]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 6'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_control) begin
            rem_q   <= 32'd0;
            quo_q   <= abs_x;
            dvs_q   <= abs_y;
            neg_q_q <= x[31] ^ y[31];
            neg_r_q <= x[31];
            cnt_q   <= 6'd32;
            busy_q  <= 1'b1;
            divz_q  <= 1'b0;
            zero_q  <= (y == 32'd0);
            state_q <= (y == 32'd0) ? FINISH : RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          // On divide-by-zero quo_q still holds |x|, so the sign fix-up restores x.
          if (zero_q) begin
            lo_q   <= 32'hFFFF_FFFF;
            hi_q   <= neg_r_q ? (~quo_q + 32'd1) : quo_q;
            divz_q <= 1'b1;
          end else begin
            lo_q   <= neg_q_q ? (~quo_q + 32'd1) : quo_q;
            hi_q   <= neg_r_q ? (~rem_q + 32'd1) : rem_q;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign operando = busy_q;
  assign done     = done_q;
  assign div_zero = divz_q;

endmodule

`default_nettype wire

// File: tb/tb_div.sv
// ============================================================================
// Module   : tb_div
// Purpose  : Self-checking bench for div: vector table, random operands
//            against an arithmetic reference, hold/abort corner sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div;

  logic        clk;
  logic        reset;
  logic [31:0] x;
  logic [31:0] y;
  logic        div_control;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        operando;
  logic        done;
  logic        div_zero;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_hi = 32'd0;
  logic [31:0] prev_lo = 32'd0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] el;
    logic [31:0] eh;
    logic        ez;
  } vec_t;

  vec_t tv [7];

  div dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .div_control(div_control),
    .hi         (hi),
    .lo         (lo),
    .operando   (operando),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic in 64 bits (truncating division).
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] l, output logic [31:0] h,
                                  output logic z);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      l = 32'hFFFF_FFFF;
      h = a;
      z = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      l  = q[31:0];
      h  = r[31:0];
      z  = 1'b0;
    end
  endfunction

  // Called at the negedge right after the acceptance edge.
  task automatic wait_result(input string tag, input int exp_k, input logic [31:0] el,
                             input logic [31:0] eh, input logic ez, input bit scramble);
    int k;
    bit bad;
    k   = 0;
    bad = 1'b0;
    chk({tag, " busy_after_start"}, {31'd0, operando}, 32'd1);
    chk({tag, " dz_cleared"}, {31'd0, div_zero}, 32'd0);
    while (done !== 1'b1 && k < 60) begin
      if (operando !== 1'b1 || hi !== prev_hi || lo !== prev_lo) bad = 1'b1;
      @(negedge clk);
      if (scramble && done !== 1'b1) begin
        x = $urandom;
        y = $urandom;
      end
      k++;
    end
    chk({tag, " hold_during_run"}, {31'd0, bad}, 32'd0);
    chk({tag, " latency"}, k, exp_k);
    chk({tag, " lo"}, lo, el);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, ez});
    chk({tag, " busy_dropped"}, {31'd0, operando}, 32'd0);
    prev_hi = eh;
    prev_lo = el;
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  // Called at a negedge; drives the request, accepted at the next posedge.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] el, input logic [31:0] eh, input logic ez);
    x = a;
    y = b;
    div_control = 1'b1;
    @(negedge clk);
    div_control = 1'b0;
    wait_result(tag, (b == 32'd0) ? 1 : 33, el, eh, ez, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb, rl, rh;
    logic        rz;
    int          t;

    tv[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tv[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    tv[2] = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    tv[3] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
    tv[4] = '{32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1};
    tv[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tv[6] = '{32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0};

    reset = 1'b0;
    div_control = 1'b0;
    x = 32'd0;
    y = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset operando", {31'd0, operando}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);

    // Release and request together: first edge after release must accept.
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].el, tv[i].eh, tv[i].ez);
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        t  = int'($urandom_range(0, 20)) - 10;
        rb = t;
      end
      if ($urandom_range(0, 3) == 0) begin
        t  = int'($urandom_range(0, 200)) - 100;
        ra = t;
      end
      ref_div(ra, rb, rl, rh, rz);
      do_op($sformatf("rnd%0d", i), ra, rb, rl, rh, rz);
    end

    // Start held high with operands scrambled during RUN, then re-accept in IDLE.
    x = 32'd100;
    y = 32'd7;
    div_control = 1'b1;
    @(negedge clk);
    wait_result("held", 33, 32'd14, 32'd2, 1'b0, 1'b1);
    div_control = 1'b0;
    ref_div(x, y, rl, rh, rz);
    wait_result("held_next", (y == 32'd0) ? 1 : 33, rl, rh, rz, 1'b0);

    // Asynchronous reset in the middle of RUN.
    x = 32'd100;
    y = 32'd7;
    div_control = 1'b1;
    @(negedge clk);
    div_control = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort operando", {31'd0, operando}, 32'd0);
    chk("abort div_zero", {31'd0, div_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort no_done", {31'd0, done}, 32'd0);
    prev_hi = 32'd0;
    prev_lo = 32'd0;
    reset = 1'b1;
    do_op("post_reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
